// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl: round sequencer for the two-player LED quiz game.
// Steps the question index, arbitrates the two buzzers (first rising edge
// wins, round-robin on same-cycle presses), judges the granted answer,
// keeps both scores and declares the winner at game end.
module quiz_round_ctrl #(
    parameter int NUM_Q          = 6,
    parameter int WIN_SCORE      = 5,
    parameter int SHOW_CYCLES    = 16,
    parameter int ANSWER_TIMEOUT = 255,
    parameter int RESULT_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       buzz_p1,
    input  logic       buzz_p2,
    input  logic [2:0] sel_p1,
    input  logic [2:0] sel_p2,
    input  logic [2:0] ans,
    output logic [2:0] q_idx,
    output logic       show_en,
    output logic       armed,
    output logic [1:0] grant,
    output logic       correct,
    output logic       wrong,
    output logic [2:0] score_p1,
    output logic [2:0] score_p2,
    output logic       game_over,
    output logic [1:0] winner
);

    // One shared phase counter, sized for the longest phase it has to time.
    localparam int MAX_SA  = (SHOW_CYCLES > ANSWER_TIMEOUT) ? SHOW_CYCLES : ANSWER_TIMEOUT;
    localparam int CNT_MAX = (MAX_SA > RESULT_CYCLES) ? MAX_SA : RESULT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(ANSWER_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RES_LAST  = CNT_W'(RESULT_CYCLES - 1);
    localparam logic [2:0]       WIN_S     = 3'(WIN_SCORE);
    localparam logic [2:0]       LAST_Q    = 3'(NUM_Q - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHOW,
        S_ARMED,
        S_JUDGE,
        S_RESULT,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       q_idx_q, q_idx_d;
    logic [2:0]       score1_q, score1_d;
    logic [2:0]       score2_q, score2_d;
    logic [1:0]       grant_q, grant_d;
    logic [2:0]       sel_q, sel_d;
    logic             rr_p2_q, rr_p2_d;    // 0: p1 wins the next tie, 1: p2
    logic             correct_q, correct_d;
    logic             wrong_q, wrong_d;
    logic             prev1_q, prev2_q;

    // A press is a rising edge of the raw level; a held button stays quiet.
    logic press1, press2;
    assign press1 = buzz_p1 & ~prev1_q;
    assign press2 = buzz_p2 & ~prev2_q;

    // State register plus all datapath registers of the round.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            q_idx_q   <= '0;
            score1_q  <= '0;
            score2_q  <= '0;
            grant_q   <= '0;
            sel_q     <= '0;
            rr_p2_q   <= 1'b0;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            prev1_q   <= 1'b0;
            prev2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            q_idx_q   <= q_idx_d;
            score1_q  <= score1_d;
            score2_q  <= score2_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            rr_p2_q   <= rr_p2_d;
            correct_q <= correct_d;
            wrong_q   <= wrong_d;
            prev1_q   <= buzz_p1;
            prev2_q   <= buzz_p2;
        end
    end

    // Next-state and next-datapath logic for the round sequencer.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned, which would infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        q_idx_d   = q_idx_q;
        score1_d  = score1_q;
        score2_d  = score2_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        rr_p2_d   = rr_p2_q;
        correct_d = 1'b0;
        wrong_d   = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_SHOW;
                    cnt_d    = '0;
                    q_idx_d  = '0;
                    score1_d = '0;
                    score2_d = '0;
                    grant_d  = '0;
                end
            end

            S_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = S_ARMED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_ARMED: begin
                if (press1 && press2) begin
                    // Tie: the pointer's player wins, then the pointer flips.
                    grant_d = rr_p2_q ? 2'b10 : 2'b01;
                    sel_d   = rr_p2_q ? sel_p2 : sel_p1;
                    rr_p2_d = ~rr_p2_q;
                    state_d = S_JUDGE;
                    cnt_d   = '0;
                end else if (press1) begin
                    grant_d = 2'b01;
                    sel_d   = sel_p1;
                    state_d = S_JUDGE;
                    cnt_d   = '0;
                end else if (press2) begin
                    grant_d = 2'b10;
                    sel_d   = sel_p2;
                    state_d = S_JUDGE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    // Nobody buzzed in time: count it as a wrong answer.
                    wrong_d = 1'b1;
                    grant_d = '0;
                    state_d = S_RESULT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_JUDGE: begin
                state_d = S_RESULT;
                cnt_d   = '0;
                if (sel_q == ans) begin
                    correct_d = 1'b1;
                    if (grant_q[0] && (score1_q < WIN_S)) score1_d = score1_q + 3'd1;
                    if (grant_q[1] && (score2_q < WIN_S)) score2_d = score2_q + 3'd1;
                end else begin
                    wrong_d = 1'b1;
                end
            end

            S_RESULT: begin
                if (cnt_q == RES_LAST) begin
                    grant_d = '0;
                    cnt_d   = '0;
                    if ((score1_q == WIN_S) || (score2_q == WIN_S) || (q_idx_q == LAST_Q)) begin
                        state_d = S_DONE;
                    end else begin
                        q_idx_d = q_idx_q + 3'd1;
                        state_d = S_SHOW;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Winner is decoded from the frozen final scores while in DONE.
    always_comb begin
        winner = 2'b00;
        if (state_q == S_DONE) begin
            if (score1_q > score2_q)      winner = 2'b01;
            else if (score2_q > score1_q) winner = 2'b10;
            else                          winner = 2'b11;
        end
    end

    assign q_idx     = q_idx_q;
    assign show_en   = (state_q == S_SHOW) || (state_q == S_ARMED) ||
                       (state_q == S_JUDGE) || (state_q == S_RESULT);
    assign armed     = (state_q == S_ARMED);
    assign grant     = grant_q;
    assign correct   = correct_q;
    assign wrong     = wrong_q;
    assign score_p1  = score1_q;
    assign score_p2  = score2_q;
    assign game_over = (state_q == S_DONE);

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// tb_quiz_round_ctrl: randomized self-checking bench for quiz_round_ctrl.
// The reference model tracks the game at question granularity (scores,
// question index, tie pointer) and predicts each phase from its duration.
module tb_quiz_round_ctrl;

    localparam int NUM_Q          = 6;
    localparam int WIN_SCORE      = 5;
    localparam int SHOW_CYCLES    = 16;
    localparam int ANSWER_TIMEOUT = 255;
    localparam int RESULT_CYCLES  = 8;

    logic       clk = 1'b0;
    logic       rst_n, start, buzz_p1, buzz_p2;
    logic [2:0] sel_p1, sel_p2, ans;
    logic [2:0] q_idx, score_p1, score_p2;
    logic       show_en, armed, correct, wrong, game_over;
    logic [1:0] grant, winner;

    quiz_round_ctrl #(
        .NUM_Q(NUM_Q), .WIN_SCORE(WIN_SCORE), .SHOW_CYCLES(SHOW_CYCLES),
        .ANSWER_TIMEOUT(ANSWER_TIMEOUT), .RESULT_CYCLES(RESULT_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .buzz_p1(buzz_p1), .buzz_p2(buzz_p2),
        .sel_p1(sel_p1), .sel_p2(sel_p2), .ans(ans),
        .q_idx(q_idx), .show_en(show_en), .armed(armed), .grant(grant),
        .correct(correct), .wrong(wrong),
        .score_p1(score_p1), .score_p2(score_p2),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    int         m_s1, m_s2, m_q;
    bit         m_rr_p2;
    logic [2:0] ans_tab [NUM_Q];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] exp_winner();
        if (m_s1 > m_s2) return 2'b01;
        if (m_s2 > m_s1) return 2'b10;
        return 2'b11;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_q_idx"},  32'(q_idx), 0);
        check({tag, "_show"},   32'(show_en), 0);
        check({tag, "_armed"},  32'(armed), 0);
        check({tag, "_grant"},  32'(grant), 0);
        check({tag, "_pulse"},  32'({correct, wrong}), 0);
        check({tag, "_score1"}, 32'(score_p1), 0);
        check({tag, "_score2"}, 32'(score_p2), 0);
        check({tag, "_over"},   32'(game_over), 0);
        check({tag, "_winner"}, 32'(winner), 0);
    endtask

    task automatic start_game();
        foreach (ans_tab[i]) ans_tab[i] = 3'($urandom_range(0, 7));
        ans   = ans_tab[0];
        start = 1'b1;
        tick();
        start = 1'b0;
        m_q = 0; m_s1 = 0; m_s2 = 0;
        check("start_show_en", 32'(show_en), 1);
        check("start_q_idx",   32'(q_idx), 0);
        check("start_score1",  32'(score_p1), 0);
        check("start_score2",  32'(score_p2), 0);
        check("start_over",    32'(game_over), 0);
    endtask

    // One question, entered on the first SHOW cycle. mode: 0 p1 press,
    // 1 p2 press, 2 both in the same cycle, 3 timeout, 4 p2 held from SHOW
    // then released and re-pressed. right: 0 wrong, 1 right, 2 random.
    task automatic play_question(input int mode, input int right, input bit abort,
                                 output bit ended);
        int         d;
        bit         p1, p2, win2, ok;
        logic [2:0] wsel;
        logic [1:0] gexp;
        ended = 1'b0;
        ok    = 1'b0;
        ans   = ans_tab[m_q];

        for (int i = 0; i < SHOW_CYCLES; i++) begin
            check("show_not_armed", 32'(armed), 0);
            check("show_grant", 32'(grant), 0);
            if (i == SHOW_CYCLES - 1) begin
                buzz_p1 = 1'b0;
                buzz_p2 = (mode == 4);
            end else begin
                buzz_p1 = 1'($urandom_range(0, 1));
                buzz_p2 = (mode == 4) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            tick();
        end
        check("armed_entry", 32'(armed), 1);
        check("armed_q_idx", 32'(q_idx), 32'(m_q));
        check("armed_show_en", 32'(show_en), 1);

        if (mode == 3) begin
            for (int j = 0; j < ANSWER_TIMEOUT; j++) begin
                check("to_still_armed", 32'(armed), 1);
                buzz_p1 = 1'b0;
                buzz_p2 = 1'b0;
                start   = 1'($urandom_range(0, 1));
                tick();
            end
            start = 1'b0;
            gexp  = 2'b00;
            check("to_armed_off", 32'(armed), 0);
            check("to_wrong", 32'(wrong), 1);
            check("to_correct", 32'(correct), 0);
            check("to_grant", 32'(grant), 0);
        end else begin
            d = (mode == 4) ? $urandom_range(2, 8) : $urandom_range(0, 8);
            for (int j = 0; j < d; j++) begin
                check("wait_armed", 32'(armed), 1);
                check("wait_grant", 32'(grant), 0);
                buzz_p1 = 1'b0;
                buzz_p2 = (mode == 4) && (j < d - 1);
                start   = 1'($urandom_range(0, 1));
                tick();
            end
            start = 1'b0;
            check("press_armed", 32'(armed), 1);
            p1 = (mode == 0) || (mode == 2);
            p2 = (mode != 0);
            if (p1 && p2) begin
                win2    = m_rr_p2;
                m_rr_p2 = !m_rr_p2;
            end else begin
                win2 = p2;
            end
            ok     = (right == 2) ? 1'($urandom_range(0, 1)) : (right == 1);
            wsel   = ok ? ans : (ans ^ 3'd1);
            sel_p1 = win2 ? 3'($urandom_range(0, 7)) : wsel;
            sel_p2 = win2 ? wsel : 3'($urandom_range(0, 7));
            buzz_p1 = p1;
            buzz_p2 = p2;
            tick();
            gexp = win2 ? 2'b10 : 2'b01;
            check("grant", 32'(grant), 32'(gexp));
            check("judge_armed", 32'(armed), 0);
            check("judge_show_en", 32'(show_en), 1);
            check("judge_pulse", 32'({correct, wrong}), 0);
            // Answers may change after the press; the latched one must count.
            sel_p1  = 3'($urandom_range(0, 7));
            sel_p2  = 3'($urandom_range(0, 7));
            buzz_p1 = 1'($urandom_range(0, 1));
            buzz_p2 = 1'($urandom_range(0, 1));
            if (abort) begin
                #2 rst_n = 1'b0;
                #1 check_all_zero("abort");
                m_s1 = 0; m_s2 = 0; m_q = 0; m_rr_p2 = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
                buzz_p1 = 1'b0;
                buzz_p2 = 1'b0;
                tick();
                check_all_zero("post_abort");
                ended = 1'b1;
                return;
            end
            tick();
            check("correct", 32'(correct), 32'(ok));
            check("wrong", 32'(wrong), 32'(!ok));
            check("grant_held", 32'(grant), 32'(gexp));
            if (ok) begin
                if (win2) m_s2 = (m_s2 < WIN_SCORE) ? m_s2 + 1 : m_s2;
                else      m_s1 = (m_s1 < WIN_SCORE) ? m_s1 + 1 : m_s1;
            end
        end
        check("score1_judge", 32'(score_p1), 32'(m_s1));
        check("score2_judge", 32'(score_p2), 32'(m_s2));
        buzz_p1 = 1'b0;
        buzz_p2 = 1'b0;

        for (int k = 1; k < RESULT_CYCLES; k++) begin
            tick();
            check("result_grant", 32'(grant), 32'(gexp));
            check("result_pulse", 32'({correct, wrong}), 0);
            check("result_q_idx", 32'(q_idx), 32'(m_q));
        end
        tick();
        check("post_grant", 32'(grant), 0);
        if (m_s1 == WIN_SCORE || m_s2 == WIN_SCORE || m_q == NUM_Q - 1) begin
            ended = 1'b1;
            check("done_over", 32'(game_over), 1);
            check("done_winner", 32'(winner), 32'(exp_winner()));
            check("done_q_idx", 32'(q_idx), 32'(m_q));
            check("done_show_en", 32'(show_en), 0);
        end else begin
            m_q++;
            check("next_q_idx", 32'(q_idx), 32'(m_q));
            check("next_show_en", 32'(show_en), 1);
            check("next_over", 32'(game_over), 0);
            check("next_winner", 32'(winner), 0);
        end
        check("score1_after", 32'(score_p1), 32'(m_s1));
        check("score2_after", 32'(score_p2), 32'(m_s2));
    endtask

    // kind: 0 directed mix, 1 p1 always right, 2 random, 3 random + reset in q3 JUDGE.
    task automatic run_game(input int kind);
        bit ended, aborted;
        int mode, right, r;
        ended   = 1'b0;
        aborted = 1'b0;
        start_game();
        for (int q = 0; !ended; q++) begin
            right = 2;
            if (kind == 0) begin
                case (q)
                    0:       begin mode = 0; right = 1; end
                    1, 2:    mode = 2;
                    3:       mode = 4;
                    4:       mode = 3;
                    default: mode = 1;
                endcase
            end else if (kind == 1) begin
                mode  = 0;
                right = 1;
            end else begin
                r = $urandom_range(0, 9);
                mode = (r < 3) ? 0 : (r < 6) ? 1 : (r < 8) ? 2 : (r == 8) ? 4 : 3;
            end
            aborted = (kind == 3) && (q == 3);
            if (aborted && mode == 3) mode = 2;
            play_question(mode, right, aborted, ended);
        end
        if (!aborted) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                check("dwell_over", 32'(game_over), 1);
                check("dwell_q_idx", 32'(q_idx), 32'(m_q));
                check("dwell_score1", 32'(score_p1), 32'(m_s1));
                check("dwell_score2", 32'(score_p2), 32'(m_s2));
                check("dwell_winner", 32'(winner), 32'(exp_winner()));
            end
        end
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; buzz_p1 = 1'b0; buzz_p2 = 1'b0;
        sel_p1 = '0; sel_p2 = '0; ans = '0;
        m_s1 = 0; m_s2 = 0; m_q = 0; m_rr_p2 = 1'b0;
        #1 rst_n = 1'b0;
        #3 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check_all_zero("idle");

        run_game(0);
        run_game(1);
        check("p1_five_q_idx", 32'(q_idx), 4);
        check("p1_five_winner", 32'(winner), 32'b01);
        run_game(2);
        run_game(3);
        run_game(2);
        run_game(2);
        run_game(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
